aes_result_packer: RTL

//  Downstream of the 8-bit AES FIFO wrapper: drains its output FIFO (one result byte per word, in
//  in_din[7:0]) and packs BYTES=DATA_WIDTH/8 consecutive bytes into one word for the host-side FIFO.

---
 rtl/aes_result_packer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/aes_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : aes_result_packer
//  Purpose  : Drains the 8-bit AES result FIFO (one byte per word, taken from
//             in_din_i[7:0]) and packs BYTES = DATA_WIDTH/8 consecutive bytes
//             into one word for the host-side FIFO. Byte 0 is the first byte
//             received and lands in the lowest lane. Partial words are emitted
//             on idle timeout or on flush_req_i and carry a valid-byte count.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          in   rising-edge clock
//    rst_ni         in   asynchronous active-low reset
//    in_empty_i     in   upstream FIFO empty (FWFT)
//    in_rd_o        out  upstream pop, registered one-cycle pulse
//    in_din_i       in   upstream FIFO head, only [7:0] carries data
//    out_full_i     in   downstream FIFO full
//    out_wr_o       out  downstream write, registered one-cycle pulse
//    out_dout_o     out  packed word, held between writes
//    out_nbytes_o   out  valid bytes in out_dout_o, updated with out_wr_o
//    flush_req_i    in   one-cycle request to emit the current partial word
//    word_count_o   out  words written (wraps)
//    flush_count_o  out  partial words written (wraps)
// ============================================================================
module aes_result_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  in_empty_i,
    output logic                                  in_rd_o,
    input  logic [DATA_WIDTH-1:0]                 in_din_i,
    input  logic                                  out_full_i,
    output logic                                  out_wr_o,
    output logic [DATA_WIDTH-1:0]                 out_dout_o,
    output logic [$clog2(DATA_WIDTH/8):0]         out_nbytes_o,
    input  logic                                  flush_req_i,
    output logic [CNT_WIDTH-1:0]                  word_count_o,
    output logic [CNT_WIDTH-1:0]                  flush_count_o
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int NB_W   = $clog2(BYTES) + 1;
    // Idle counter only has to reach TIMEOUT_CYCLES-1; it saturates beyond.
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        (TIMEOUT_CYCLES != 0) ? IDLE_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [NB_W-1:0] NB_FULL = NB_W'(BYTES);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_GAP     = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NB_W-1:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [DATA_WIDTH-1:0]  lanes_q, lanes_d;
    logic                   pend_q, pend_d;
    logic                   in_rd_q, in_rd_d;
    logic                   out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic [NB_W-1:0]        nbytes_q, nbytes_d;
    logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;
    logic                   timeout_hit;

    // Upper bits of the upstream word carry no data.
    logic unused_din;
    assign unused_din = ^in_din_i[DATA_WIDTH-1:8];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_q == IDLE_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        lanes_d  = lanes_q;
        pend_d   = pend_q;
        in_rd_d  = 1'b0;
        out_wr_d = 1'b0;
        dout_d   = dout_q;
        nbytes_d = nbytes_q;
        wcnt_d   = wcnt_q;
        fcnt_d   = fcnt_q;

        // A request is latched in every state; the branches below decide
        // when it is consumed or discarded.
        if (flush_req_i) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_COLLECT: begin
                if (!in_empty_i) begin
                    // A byte arriving always wins over a flush: the pending
                    // flush is served on the next COLLECT visit and the word
                    // then includes this byte.
                    for (int i = 0; i < BYTES; i++) begin
                        if (cnt_q == NB_W'(i)) begin
                            lanes_d[i*8 +: 8] = in_din_i[7:0];
                        end
                    end
                    in_rd_d = 1'b1;
                    cnt_d   = cnt_q + NB_W'(1);
                    idle_d  = '0;
                    state_d = ST_GAP;
                end else if (cnt_q != '0 && (pend_q || timeout_hit)) begin
                    state_d = ST_EMIT;
                end else if (cnt_q == '0) begin
                    // Nothing buffered: a flush has nothing to emit.
                    idle_d = '0;
                    pend_d = 1'b0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end

            ST_GAP: begin
                // One dead cycle so the upstream empty flag reflects the pop.
                state_d = (cnt_q == NB_FULL) ? ST_EMIT : ST_COLLECT;
            end

            ST_EMIT: begin
                if (!out_full_i) begin
                    out_wr_d = 1'b1;
                    dout_d   = lanes_q;
                    nbytes_d = cnt_q;
                    wcnt_d   = wcnt_q + CNT_WIDTH'(1);
                    if (cnt_q != NB_FULL) begin
                        fcnt_d = fcnt_q + CNT_WIDTH'(1);
                    end
                    cnt_d    = '0;
                    lanes_d  = '0;
                    idle_d   = '0;
                    pend_d   = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_COLLECT;
            cnt_q    <= '0;
            idle_q   <= '0;
            lanes_q  <= '0;
            pend_q   <= 1'b0;
            in_rd_q  <= 1'b0;
            out_wr_q <= 1'b0;
            dout_q   <= '0;
            nbytes_q <= '0;
            wcnt_q   <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            lanes_q  <= lanes_d;
            pend_q   <= pend_d;
            in_rd_q  <= in_rd_d;
            out_wr_q <= out_wr_d;
            dout_q   <= dout_d;
            nbytes_q <= nbytes_d;
            wcnt_q   <= wcnt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign in_rd_o       = in_rd_q;
    assign out_wr_o      = out_wr_q;
    assign out_dout_o    = dout_q;
    assign out_nbytes_o  = nbytes_q;
    assign word_count_o  = wcnt_q;
    assign flush_count_o = fcnt_q;

endmodule
`default_nettype wire
